// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: access-size encodings (the
// same one-hot codes the data memory decodes), FSM state encodings, requester
// indices, the latched command record and an access-size helper.
// No ports.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    // Access size, one-hot. Shared with the data memory.
    localparam logic [2:0] BYTE     = 3'b001;
    localparam logic [2:0] HALFWORD = 3'b010;
    localparam logic [2:0] WORD     = 3'b100;

    // Sequencer states.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Requester indices into the per-port response vectors.
    localparam int PORT_CPU  = 0;
    localparam int PORT_DBG  = 1;
    localparam int NUM_PORTS = 2;

    // Command captured from the winning requester in IDLE.
    typedef struct packed {
        logic        we;
        logic [2:0]  op;
        logic        signo;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        owner;   // 0 = CPU, 1 = debug
    } dmem_cmd_t;

    // Number of bytes touched by an op; 0 for anything that is not one-hot.
    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            BYTE:     op_size = 3'd1;
            HALFWORD: op_size = 3'd2;
            WORD:     op_size = 3'd4;
            default:  op_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// -----------------------------------------------------------------------------
// dmem_access_check
// Combinational legality check of one memory command.
//   op   in  3  : access size, one-hot
//   addr in 32  : byte address
//   err  out 1  : command must not reach memory (bad op, misaligned, or out
//                 of 0..DEPTH_BYTES-1)
// -----------------------------------------------------------------------------
module dmem_access_check
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH_BYTES = 32
) (
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic        err
);

    logic [2:0]  size;
    logic [32:0] end_addr;

    always_comb begin
        size     = op_size(op);
        // One extra bit so an address near 2^32 cannot wrap back into range.
        end_addr = {1'b0, addr} + {30'd0, size};
        err      = 1'b0;
        if (size == 3'd0) begin
            err = 1'b1;
        end else if (op == HALFWORD && addr[0]) begin
            err = 1'b1;
        end else if (op == WORD && addr[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (end_addr > 33'(DEPTH_BYTES)) begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the CPU MEM stage (priority) and
// the debug unit. Each access runs IDLE -> ACCESS -> RESP; the requester sees a
// one-cycle ack (with err) in the cycle after RESP. Illegal commands are
// answered with err=1/rdata=0 and never reach memory.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpu_req/we/op/signo/addr/wdata  CPU command (level request)
//   cpu_ack/err/rdata, cpu_stall    CPU response, stall = req & ~ack
//   dbg_req/we/op/addr/wdata        debug command (reads always unsigned)
//   dbg_ack/err/rdata               debug response
//   mem_we/op/signo/addr/din        memory command, active only in ACCESS
//   mem_dout                        memory read data (memory updates on negedge)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH_BYTES = 32,
    parameter int MAX_WAIT    = 4    // >= 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_op,
    input  logic        cpu_signo,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [2:0]  dbg_op,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,

    output logic        mem_we,
    output logic [2:0]  mem_op,
    output logic        mem_signo,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [1:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    dmem_cmd_t         cmd_reg, grant_cmd;
    logic [31:0]       dout_reg;

    logic grant_cpu, grant_dbg;
    logic chk_err;
    logic access_active, mem_enable;

    logic [NUM_PORTS-1:0]       resp_sel;
    logic [NUM_PORTS-1:0]       ack_vec, err_vec;
    logic [NUM_PORTS-1:0][31:0] rdata_vec;

    // ---------------- arbitration ----------------
    always_comb begin
        grant_dbg = dbg_req && (!cpu_req || wait_reg == WAIT_MAX);
        grant_cpu = cpu_req && !grant_dbg;

        grant_cmd = '0;
        if (grant_dbg) begin
            grant_cmd.we    = dbg_we;
            grant_cmd.op    = dbg_op;
            grant_cmd.signo = 1'b0;
            grant_cmd.addr  = dbg_addr;
            grant_cmd.wdata = dbg_wdata;
            grant_cmd.owner = 1'b1;
        end else begin
            grant_cmd.we    = cpu_we;
            grant_cmd.op    = cpu_op;
            grant_cmd.signo = cpu_signo;
            grant_cmd.addr  = cpu_addr;
            grant_cmd.wdata = cpu_wdata;
            grant_cmd.owner = 1'b0;
        end
    end

    // ---------------- sequencer ----------------
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                if (grant_cpu || grant_dbg) begin
                    state_next = ACCESS;
                    if (grant_dbg) begin
                        wait_next = '0;
                    end else if (dbg_req && wait_reg != WAIT_MAX) begin
                        wait_next = wait_reg + WAIT_W'(1);
                    end
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            wait_reg  <= '0;
            cmd_reg   <= '0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == IDLE && (grant_cpu || grant_dbg)) begin
                cmd_reg <= grant_cmd;
            end
            // Memory has produced its read data by the end of ACCESS; hold it
            // so the RESP answer does not depend on what the idle port shows.
            if (state_reg == ACCESS) begin
                dout_reg <= mem_dout;
            end
        end
    end

    // ---------------- legality check on the latched command ----------------
    dmem_access_check #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_check (
        .op   (cmd_reg.op),
        .addr (cmd_reg.addr),
        .err  (chk_err)
    );

    // ---------------- memory command ----------------
    // rst_n gates the strobes combinationally so a reset cycle can never
    // write, even when it lands on ACCESS.
    assign access_active = (state_reg == ACCESS);
    assign mem_enable    = rst_n && access_active && !chk_err;
    assign mem_we        = mem_enable && cmd_reg.we;
    assign mem_op        = mem_enable ? cmd_reg.op : 3'b000;
    assign mem_signo     = access_active ? cmd_reg.signo : 1'b0;
    assign mem_addr      = access_active ? cmd_reg.addr  : 32'd0;
    assign mem_din       = access_active ? cmd_reg.wdata : 32'd0;

    // ---------------- per-port responses ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
            logic        ack_reg;
            logic        err_reg;
            logic [31:0] rdata_reg;

            assign resp_sel[gi] = (state_reg == RESP) && (cmd_reg.owner == 1'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= resp_sel[gi];
                    err_reg <= resp_sel[gi] && chk_err;
                    if (resp_sel[gi]) begin
                        rdata_reg <= chk_err ? 32'd0 : dout_reg;
                    end
                end
            end

            assign ack_vec[gi]   = ack_reg;
            assign err_vec[gi]   = err_reg;
            assign rdata_vec[gi] = rdata_reg;
        end
    endgenerate

    assign cpu_ack   = ack_vec[PORT_CPU];
    assign cpu_err   = err_vec[PORT_CPU];
    assign cpu_rdata = rdata_vec[PORT_CPU];
    assign cpu_stall = cpu_req && !cpu_ack;

    assign dbg_ack   = ack_vec[PORT_DBG];
    assign dbg_err   = err_vec[PORT_DBG];
    assign dbg_rdata = rdata_vec[PORT_DBG];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Bench for dmem_arbiter with a byte-array data memory on the mem_* port and
// an independent arithmetic model of the expected memory contents, errors and
// read values.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DEPTH = 32;
    localparam int MAXW  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_signo = 1'b0;
    logic [2:0]  cpu_op = 3'b000;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack, cpu_err, cpu_stall;
    logic [31:0] cpu_rdata;

    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [2:0]  dbg_op = 3'b000;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_ack, dbg_err;
    logic [31:0] dbg_rdata;

    logic        mem_we, mem_signo;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout;

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;
    int txn_no = 0;

    logic [7:0] ref_mem [DEPTH];
    logic [7:0] dev_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH_BYTES(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_op(cpu_op), .cpu_signo(cpu_signo),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_op(dbg_op),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_op(mem_op), .mem_signo(mem_signo),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 59 + 90) ^ (i << 3));
    endfunction

    function automatic int op_bytes(input logic [2:0] op);
        case (op)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    // ---------------- data memory device ----------------
    initial begin : memory_device
        int sz;
        int a;
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) dev_mem[i] = init_byte(i);
        mem_dout = '0;
        forever begin
            @(negedge clk);
            if (mem_we) we_pulses++;
            if (mem_op != 3'b000) begin
                sz = op_bytes(mem_op);
                a  = int'(mem_addr[15:0]);
                if (mem_we) begin
                    for (int i = 0; i < sz; i++)
                        if (a + i < DEPTH) dev_mem[a + i] = mem_din[8*i +: 8];
                end else begin
                    v = '0;
                    for (int i = 0; i < sz; i++)
                        if (a + i < DEPTH) v[8*i +: 8] = dev_mem[a + i];
                    if (mem_signo && sz > 0 && sz < 4 && v[8*sz-1])
                        v = v | (32'hFFFF_FFFF << (8*sz));
                    mem_dout = v;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [2:0] op, input logic [31:0] addr);
        int sz;
        sz = op_bytes(op);
        if (sz == 0) return 1'b1;
        if ((longint'(addr) % sz) != 0) return 1'b1;
        if (longint'(addr) + sz > DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int sz, input logic sgn);
        longint v;
        v = 0;
        for (int i = 0; i < sz; i++) v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
        if (sgn && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request (called just after a negedge), wait for its ack.
    task automatic txn(input int port, input logic we, input logic [2:0] op, input logic signo,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int stalls, output logic timed_out);
        if (port == 0) begin
            cpu_req = 1'b1; cpu_we = we; cpu_op = op; cpu_signo = signo;
            cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_op = op;
            dbg_addr = addr; dbg_wdata = wdata;
        end
        #1;
        lat = 0;
        stalls = 0;
        while (!(port == 0 ? cpu_ack : dbg_ack) && lat < 20) begin
            if (cpu_stall) stalls++;
            @(negedge clk); #1;
            lat++;
        end
        timed_out = (lat >= 20);
        rdata = (port == 0) ? cpu_rdata : dbg_rdata;
        err   = (port == 0) ? cpu_err : dbg_err;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk); #1;
        check("ack_one_cycle", 32'(port == 0 ? cpu_ack : dbg_ack), 32'd0);
    endtask

    task automatic run_and_check(input string tag, input int port, input logic we,
                                 input logic [2:0] op, input logic signo,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd);
        logic        e_err, err, tmo;
        logic [31:0] e_rd;
        int          sz, lat, stalls, p0;
        sz    = op_bytes(op);
        e_err = model_err(op, addr);
        e_rd  = (e_err || we) ? 32'd0 : model_read(addr, sz, signo && port == 0);
        p0    = we_pulses;
        txn(port, we, op, signo, addr, wdata, rd, err, lat, stalls, tmo);
        check({tag, "/timeout"}, 32'(tmo), 32'd0);
        check({tag, "/err"}, 32'(err), 32'(e_err));
        if (!we || e_err) check({tag, "/rdata"}, rd, e_rd);
        check({tag, "/latency"}, 32'(lat), 32'd3);
        if (port == 0) check({tag, "/stall_cycles"}, 32'(stalls), 32'd3);
        check({tag, "/we_pulses"}, 32'(we_pulses - p0), 32'(we && !e_err));
        if (we && !e_err)
            for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        txn_no++;
        $display("txn %0d %s port=%s we=%0d op=%b signo=%0d addr=0x%02h wdata=0x%08h -> err=%0d rdata=0x%08h lat=%0d",
                 txn_no, tag, port == 0 ? "cpu" : "dbg", we, op, signo, addr, wdata, err, rd, lat);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] rd;
        string       order;
        int          cyc, p0;
        logic        ack_seen;
        logic [2:0]  rop;
        int          r;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset/ctrl", 32'({cpu_ack, cpu_err, dbg_ack, dbg_err, cpu_stall, mem_we, mem_op, mem_signo}), 32'd0);
        check("reset/cpu_rdata", cpu_rdata, 32'd0);
        check("reset/dbg_rdata", dbg_rdata, 32'd0);
        check("reset/mem_addr", mem_addr, 32'd0);
        check("reset/mem_din", mem_din, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Word write then signed byte read of its top byte
        run_and_check("cpu_wr_word", 0, 1'b1, 3'b100, 1'b0, 32'h04, 32'hDEAD_BEEF, rd);
        run_and_check("cpu_rd_sbyte", 0, 1'b0, 3'b001, 1'b1, 32'h07, 32'h0, rd);
        check("cpu_rd_sbyte/value", rd, 32'hFFFF_FFDE);
        run_and_check("cpu_rd_ubyte", 0, 1'b0, 3'b001, 1'b0, 32'h07, 32'h0, rd);
        run_and_check("cpu_rd_shalf", 0, 1'b0, 3'b010, 1'b1, 32'h06, 32'h0, rd);

        // Rejected CPU writes: misaligned half, word over the end, non one-hot op
        run_and_check("rej_half_0x03", 0, 1'b1, 3'b010, 1'b0, 32'h03, 32'h1111_1111, rd);
        run_and_check("rej_word_0x1e", 0, 1'b1, 3'b100, 1'b0, 32'h1E, 32'h2222_2222, rd);
        run_and_check("rej_op_011", 0, 1'b1, 3'b011, 1'b0, 32'h00, 32'h3333_3333, rd);
        run_and_check("rej_op_000_rd", 0, 1'b0, 3'b000, 1'b1, 32'h08, 32'h0, rd);
        run_and_check("rej_word_0x20", 0, 1'b0, 3'b100, 1'b0, 32'h20, 32'h0, rd);
        run_and_check("rej_huge_addr", 0, 1'b0, 3'b001, 1'b0, 32'hFFFF_FFFF, 32'h0, rd);

        // Boundaries
        run_and_check("dbg_wr_word_0x1c", 1, 1'b1, 3'b100, 1'b0, 32'h1C, 32'hA5C3_0F81, rd);
        run_and_check("dbg_rd_half_0x1f", 1, 1'b0, 3'b010, 1'b0, 32'h1F, 32'h0, rd);
        run_and_check("cpu_rd_sbyte_0x1f", 0, 1'b0, 3'b001, 1'b1, 32'h1F, 32'h0, rd);
        run_and_check("cpu_rd_shalf_0x1e", 0, 1'b0, 3'b010, 1'b1, 32'h1E, 32'h0, rd);
        run_and_check("dbg_rd_half_unsigned", 1, 1'b0, 3'b010, 1'b0, 32'h1E, 32'h0, rd);

        // Both requesters held high: four CPU grants, then debug
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_op = 3'b100; cpu_signo = 1'b0; cpu_addr = 32'h00;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_op = 3'b100; dbg_addr = 32'h08;
        order = "";
        cyc = 0;
        while (order.len() < 10 && cyc < 60) begin
            @(negedge clk); #1;
            cyc++;
            if (cpu_ack) begin
                order = {order, "C"};
                check("fair/cpu_rdata", cpu_rdata, model_read(32'h00, 4, 1'b0));
            end
            if (dbg_ack) begin
                order = {order, "D"};
                check("fair/dbg_rdata", dbg_rdata, model_read(32'h08, 4, 1'b0));
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        checks++;
        assert (order == "CCCCDCCCCD") else begin
            errors++;
            $error("FAIL fair/grant_order observed=%s expected=CCCCDCCCCD", order);
        end
        check("fair/cycles", 32'(cyc), 32'd30);
        $display("txn fairness order=%s cycles=%0d", order, cyc);
        @(negedge clk); #1;

        // Randomized single accesses
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 7));
            if (r < 2)      rop = 3'b001;
            else if (r < 4) rop = 3'b010;
            else if (r < 6) rop = 3'b100;
            else            rop = 3'($urandom);
            run_and_check("rand", int'($urandom_range(0, 1)), 1'($urandom), rop, 1'($urandom),
                          32'($urandom_range(0, 35)), $urandom, rd);
        end

        // Reset landing on the ACCESS cycle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_op = 3'b100; cpu_signo = 1'b0;
        cpu_addr = 32'h10; cpu_wdata = 32'h1234_5678;
        p0 = we_pulses;
        @(posedge clk); #1;
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("rst_mid/mem_we", 32'(mem_we), 32'd0);
        check("rst_mid/mem_op", 32'(mem_op), 32'd0);
        @(posedge clk); #1;
        check("rst_mid/ctrl", 32'({cpu_ack, cpu_err, dbg_ack, dbg_err, cpu_stall, mem_we, mem_op, mem_signo}), 32'd0);
        check("rst_mid/cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mid/dbg_rdata", dbg_rdata, 32'd0);
        check("rst_mid/mem_addr", mem_addr, 32'd0);
        check("rst_mid/mem_din", mem_din, 32'd0);
        rst_n = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (cpu_ack) ack_seen = 1'b1;
        end
        check("rst_mid/no_ack", 32'(ack_seen), 32'd0);
        check("rst_mid/we_pulses", 32'(we_pulses - p0), 32'd0);
        $display("txn reset_during_access ack_seen=%0d", ack_seen);

        // Memory dump through the debug port
        for (int a = 0; a < DEPTH; a += 4)
            run_and_check("dump", 1, 1'b0, 3'b100, 1'b0, 32'(a), 32'h0, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
